parity_stream: RTL and testbench
================================

PARITY_STREAM -- requirements
Module: parity_stream

Interface
REQ-001 SHALL provide parameter WIDTH, default 7, data word width in bits (WIDTH >= 1).
REQ-002 SHALL provide parameter CHUNK, default 4, bits reduced per cycle (1 <= CHUNK <= WIDTH); NCHUNK = ceil(WIDTH/CHUNK).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port D  input  WIDTH  data word.
REQ-006 SHALL have port D_valid  input  1  D is presented.
REQ-007 SHALL have port D_ready  output  1  block accepts D this cycle.
REQ-008 SHALL have port D_last  input  1  last word of frame; present only when PARITY_FRAME_EN is defined.
REQ-009 SHALL have port odd_mode  input  1  0 = even parity, 1 = odd parity; sampled at word accept.
REQ-010 SHALL have port F  output  1  parity result.
REQ-011 SHALL have port F_valid  output  1  F holds a result.
REQ-012 SHALL have port F_ready  input  1  consumer takes F.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, REDUCE, DONE.
REQ-015 IDLE: D_ready = 1; on D_valid high, capture D into shift register, latch odd_mode, clear count, go REDUCE.
REQ-016 D_ready SHALL be 0 in REDUCE and DONE; D_valid ignored there.
REQ-017 REDUCE: each cycle acc <= acc XOR (XOR of low CHUNK bits of shift register); shift register shifts right by CHUNK with zero fill; count increments.
REQ-018 Final chunk when WIDTH not a multiple of CHUNK SHALL be zero-padded (padding does not affect parity).
REQ-019 After the NCHUNK-th REDUCE cycle the FSM SHALL go DONE (frame behaviour per REQ-027).
REQ-020 DONE: F_valid = 1, F = acc XOR latched odd_mode; F and F_valid stable until F_ready high.
REQ-021 DONE with F_ready high: go IDLE, clear acc; next word accepted no earlier than the following cycle.
REQ-022 Latency: word accepted at edge t -> F_valid high after edge t+NCHUNK (CHUNK = WIDTH gives 1 cycle).
REQ-023 F SHALL be 0 whenever F_valid is 0.
REQ-024 Changes on D or odd_mode after accept SHALL NOT affect the in-flight result.

Reset
REQ-025 rst high at a rising edge SHALL force IDLE, acc = 0, count = 0, shift register = 0, odd_mode latch = 0, frame state cleared, regardless of current state (including mid-REDUCE and DONE).
REQ-026 Reset values: D_ready = 1, F = 0, F_valid = 0, busy = 0; an aborted word produces no result.

Configuration
REQ-027 Macro PARITY_FRAME_EN defined: D_last sampled at accept; after NCHUNK REDUCE cycles, if D_last was 0 go IDLE keeping acc (no F_valid), else go DONE; result covers all words of the frame; odd_mode latched from the first word of the frame.
REQ-028 PARITY_FRAME_EN undefined: D_last absent, every word is a one-word frame, acc cleared at each accept.

Verification
REQ-029 WIDTH=7, CHUNK=4, odd_mode=0, D=7'b1010011 -> F_valid after 2 edges, F=0; same with odd_mode=1 -> F=1.
REQ-030 WIDTH=7, CHUNK=4, D=7'b1000000 (bit in padded final chunk), odd_mode=0 -> F=1; D=7'b0000000 -> F=0.
REQ-031 F_ready held 0 for 5 cycles in DONE -> F, F_valid constant, D_ready=0; F_ready=1 -> next cycle IDLE, D_ready=1.
REQ-032 rst pulsed one cycle after accept (mid-REDUCE) -> F_valid never asserts for that word; next word D=7'h01 -> F=1.
REQ-033 PARITY_FRAME_EN, odd_mode=0: words 7'h01 (last=0), 7'h03 (last=0), 7'h07 (last=1) -> single F_valid after third word, F=0 (6 ones).
REQ-034 CHUNK=WIDTH=7, back-to-back D_valid with F_ready=1 -> one result per 3 cycles (IDLE, REDUCE, DONE), each F equals XOR of its word.

Source files
------------

// File: rtl/parity_stream.sv
// -----------------------------------------------------------------------------
// parity_stream
//   Computes the even or odd parity of a WIDTH-bit word by reducing CHUNK bits
//   per clock. One word is in flight at a time. The result is held on F until
//   the consumer takes it with F_ready.
//
//   Parameters
//     WIDTH    data word width in bits (>= 1)
//     CHUNK    bits reduced per cycle (1 <= CHUNK <= WIDTH)
//
//   Ports
//     clk       single clock, rising edge
//     rst       synchronous active-high reset
//     D         data word
//     D_valid   D is presented
//     D_ready   block accepts D this cycle (IDLE only)
//     D_last    last word of frame (only with PARITY_FRAME_EN)
//     odd_mode  0 = even parity, 1 = odd parity, sampled at accept
//     F         parity result, forced to 0 while F_valid is low
//     F_valid   F holds a result
//     F_ready   consumer takes F
//     busy      high whenever the FSM is not IDLE
//
//   Build option
//     PARITY_FRAME_EN  when defined, parity accumulates across all words of a
//                      frame delimited by D_last; odd_mode is taken from the
//                      first word of the frame. When undefined, every word is
//                      its own frame.
// -----------------------------------------------------------------------------
module parity_stream #(
  parameter int WIDTH = 7,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  input  logic             D_valid,
  output logic             D_ready,
`ifdef PARITY_FRAME_EN
  input  logic             D_last,
`endif
  input  logic             odd_mode,
  output logic             F,
  output logic             F_valid,
  input  logic             F_ready,
  output logic             busy
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  // Shift register is padded up to a whole number of chunks; the zero
  // padding bits cannot change the parity.
  localparam int PW     = NCHUNK * CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PW-1:0]    sh;
  logic [CNT_W-1:0] cnt;
  logic             acc;
  logic             odd_lat;
  logic             frame_end;

`ifdef PARITY_FRAME_EN
  logic             last_lat;
  logic             in_frame;   // a frame has started and not yet produced F

  assign frame_end = last_lat;
`else
  assign frame_end = 1'b1;
`endif

  function automatic logic chunk_par(input logic [CHUNK-1:0] c);
    return ^c;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (D_valid) begin
          state_nxt = REDUCE;
        end
      end
      REDUCE: begin
        if (cnt == LAST_CNT) begin
          // Mid-frame words return to IDLE keeping acc; the last word reports.
          state_nxt = frame_end ? DONE : IDLE;
        end
      end
      DONE: begin
        if (F_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture, chunked reduction, result hold
  always_ff @(posedge clk) begin
    if (rst) begin
      sh      <= '0;
      cnt     <= '0;
      acc     <= 1'b0;
      odd_lat <= 1'b0;
`ifdef PARITY_FRAME_EN
      last_lat <= 1'b0;
      in_frame <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (D_valid) begin
            sh  <= PW'(D);
            cnt <= '0;
`ifdef PARITY_FRAME_EN
            // Only the first word of a frame clears acc and latches odd_mode.
            if (!in_frame) begin
              acc     <= 1'b0;
              odd_lat <= odd_mode;
            end
            in_frame <= 1'b1;
            last_lat <= D_last;
`else
            acc     <= 1'b0;
            odd_lat <= odd_mode;
`endif
          end
        end
        REDUCE: begin
          acc <= acc ^ chunk_par(sh[CHUNK-1:0]);
          sh  <= sh >> CHUNK;
          cnt <= cnt + CNT_W'(1);
        end
        DONE: begin
          if (F_ready) begin
            acc <= 1'b0;
`ifdef PARITY_FRAME_EN
            in_frame <= 1'b0;
`endif
          end
        end
        default: begin
          acc <= 1'b0;
        end
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    D_ready = (state == IDLE);
    F_valid = (state == DONE);
    busy    = (state != IDLE);
    F       = (state == DONE) ? (acc ^ odd_lat) : 1'b0;
  end

endmodule

// File: tb/tb_parity_stream.sv
module tb_parity_stream;

  localparam int WIDTH  = 7;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] D = '0;
  logic             D_valid = 1'b0;
  logic             D_ready;
  logic             odd_mode = 1'b0;
  logic             F;
  logic             F_valid;
  logic             F_ready = 1'b1;
  logic             busy;
`ifdef PARITY_FRAME_EN
  logic             D_last = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rdy_mode = 0;   // 0: F_ready=1, 1: random, 2: F_ready=0
  logic chk_en = 1'b0;

  parity_stream #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk      (clk),
    .rst      (rst),
    .D        (D),
    .D_valid  (D_valid),
    .D_ready  (D_ready),
`ifdef PARITY_FRAME_EN
    .D_last   (D_last),
`endif
    .odd_mode (odd_mode),
    .F        (F),
    .F_valid  (F_valid),
    .F_ready  (F_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       F_ready = 1'b1;
      1:       F_ready = ($urandom_range(0, 2) != 0);
      default: F_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic par;
    int   t;     // cycle count after the accepting edge of the reporting word
  } exp_t;

  exp_t q[$];
  logic fv_prev = 1'b0;
  logic f_open  = 1'b0;
  logic f_par   = 1'b0;
  logic f_odd   = 1'b0;

  function automatic logic word_par(input logic [WIDTH-1:0] w);
    return ($countones(w) % 2) == 1;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (F_valid) begin
        if (q.size() == 0) begin
          chk("spurious_F_valid", F_valid, 1'b0);
        end else begin
          if (!fv_prev) chk("latency_on_time", (cyc == q[0].t + NCHUNK), 1'b1);
          chk("F_value", F, q[0].par);
          if (F_ready) void'(q.pop_front());
        end
        chk("D_ready_low_in_done", D_ready, 1'b0);
      end else begin
        chk("F_zero_when_invalid", F, 1'b0);
        if (q.size() > 0 && cyc == q[0].t + NCHUNK)
          chk("latency_not_late", F_valid, 1'b1);
      end
      chk("busy_vs_ready", busy, !D_ready);
      fv_prev = F_valid && !F_ready;

      if (rst) begin
        q.delete();
        f_open  = 1'b0;
        fv_prev = 1'b0;
      end else if (D_valid && D_ready) begin
`ifdef PARITY_FRAME_EN
        if (!f_open) begin
          f_open = 1'b1;
          f_odd  = odd_mode;
          f_par  = 1'b0;
        end
        f_par = f_par ^ word_par(D);
        if (D_last) begin
          q.push_back('{par: f_par ^ f_odd, t: cyc + 1});
          f_open = 1'b0;
        end
`else
        q.push_back('{par: word_par(D) ^ odd_mode, t: cyc + 1});
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Presents a word and holds it until accepted; returns at accept edge + 1.
  task automatic send(input logic [WIDTH-1:0] d, input logic om, input logic lst);
    logic ok;
    ok = 1'b0;
    D = d;
    odd_mode = om;
    D_valid = 1'b1;
`ifdef PARITY_FRAME_EN
    D_last = lst;
`else
    if (lst !== 1'b0 && lst !== 1'b1) $display("note: undefined last flag");
`endif
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (D_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("send_accepted", ok, 1'b1);
    align();
    D_valid = 1'b0;
    // Scramble inputs after accept; the in-flight result must not change.
    D = WIDTH'($urandom);
    odd_mode = 1'($urandom);
  endtask

  // Waits for F_valid, checks F against a fixed value, ends at posedge + 1.
  task automatic wait_result(input string name, input logic exp);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (F_valid) break;
    end
    chk({name, "_valid"}, F_valid, 1'b1);
    chk(name, F, exp);
    align();
  endtask

  initial begin
    repeat (3) align();
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_D_ready", D_ready, 1'b1);
    chk("reset_F", F, 1'b0);
    chk("reset_F_valid", F_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    align();

    send(7'b1010011, 1'b0, 1'b1);
    wait_result("even_1010011", 1'b0);
    send(7'b1010011, 1'b1, 1'b1);
    wait_result("odd_1010011", 1'b1);
    send(7'b1000000, 1'b0, 1'b1);
    wait_result("pad_chunk_bit", 1'b1);
    send(7'b0000000, 1'b0, 1'b1);
    wait_result("all_zero", 1'b0);

    // Consumer stalls for 5 cycles in DONE
    rdy_mode = 2;
    send(7'h55, 1'b0, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (F_valid) break;
    end
    for (int i = 0; i < 5; i++) begin
      chk("hold_F_valid", F_valid, 1'b1);
      chk("hold_F", F, 1'b0);
      chk("hold_D_ready", D_ready, 1'b0);
      @(negedge clk);
    end
    rdy_mode = 0;
    @(posedge clk);
    #2;
    @(posedge clk);
    @(negedge clk);
    chk("release_D_ready", D_ready, 1'b1);
    chk("release_F_valid", F_valid, 1'b0);
    align();

    // Reset one cycle after accept aborts the word
    send(7'h7F, 1'b0, 1'b1);
    rst = 1'b1;
    align();
    rst = 1'b0;
    send(7'h01, 1'b0, 1'b1);
    wait_result("after_abort", 1'b1);

`ifdef PARITY_FRAME_EN
    send(7'h01, 1'b0, 1'b0);
    send(7'h03, 1'b0, 1'b0);
    send(7'h07, 1'b0, 1'b1);
    wait_result("frame_three_words", 1'b0);
`endif

    // Randomized traffic with random consumer back-pressure
    rdy_mode = 1;
    for (int n = 0; n < 300; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) align();
      send(WIDTH'($urandom), 1'($urandom), ($urandom_range(0, 1) == 1));
    end
    send(WIDTH'($urandom), 1'($urandom), 1'b1);
    rdy_mode = 0;
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) break;
      align();
    end
    chk("scoreboard_drained", (q.size() == 0), 1'b1);
    repeat (2) align();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
